// File: rtl/r2r_dac_pkg.sv
// Shared mode and direction encodings for the R2R ladder waveform generator.
package r2r_dac_pkg;

  typedef enum logic [1:0] {
    MODE_EXT = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/r2r_step_divider.sv
// Programmable step divider: counts 0..div and raises step_en on the terminal count.
module r2r_step_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_data_i,
  output logic             step_en_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // A clear (mode change) outranks a load, which in turn suppresses a due step.
  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    step_en_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      div_d = div_data_i;
      cnt_d = '0;
    end else if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d     = '0;
      step_en_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/r2r_dac_wavegen.sv
// R2R ladder waveform generator: EXT / SAW / TRI / SQR with step and wrap strobes.
// Optional amplitude port enabled by defining R2R_WAVEGEN_AMP_EN.
module r2r_dac_wavegen
  import r2r_dac_pkg::*;
#(
  parameter int DAC_W = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DAC_W-1:0] data,
  input  logic [DIV_W-1:0] div_data,
  input  logic             load_divider,
`ifdef R2R_WAVEGEN_AMP_EN
  input  logic [DAC_W-1:0] amp,
`endif
  output logic [DAC_W-1:0] r2r_out,
  output logic             step,
  output logic             wrap
);

  localparam logic [DAC_W-1:0] ONE = {{(DAC_W-1){1'b0}}, 1'b1};

  logic [DAC_W-1:0] peak;
  logic [1:0]       mode_q;
  logic             mode_chg;
  logic             step_en;
  logic [DAC_W-1:0] phase_q, phase_d;
  dir_e             dir_q, dir_d;
  logic [DAC_W-1:0] r2r_out_q, r2r_out_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

`ifdef R2R_WAVEGEN_AMP_EN
  assign peak = amp;
`else
  assign peak = '1;
`endif

  assign mode_chg = (mode != mode_q);

  r2r_step_divider #(.DIV_W(DIV_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (mode_chg),
    .run_i      (mode != MODE_EXT),
    .load_i     (load_divider),
    .div_data_i (div_data),
    .step_en_o  (step_en)
  );

  always_comb begin
    phase_d   = phase_q;
    dir_d     = dir_q;
    r2r_out_d = r2r_out_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    if (mode_chg) begin
      phase_d   = '0;
      dir_d     = DIR_UP;
      r2r_out_d = '0;
    end else if (mode == MODE_EXT) begin
      r2r_out_d = data;
    end else if (step_en) begin
      step_d = 1'b1;
      case (mode)
        MODE_TRI: begin
          // An UP phase already at or above PEAK (PEAK lowered) turns around immediately.
          if (dir_q == DIR_UP) begin
            if (peak == '0) begin
              phase_d = '0;
              wrap_d  = 1'b1;
            end else if (phase_q >= peak) begin
              phase_d = phase_q - ONE;
              dir_d   = DIR_DOWN;
            end else begin
              phase_d = phase_q + ONE;
              if (phase_d >= peak) dir_d = DIR_DOWN;
            end
          end else if (phase_q <= ONE) begin
            phase_d = '0;
            dir_d   = DIR_UP;
            wrap_d  = 1'b1;
          end else begin
            phase_d = phase_q - ONE;
          end
        end
        default: begin
          if (phase_q >= peak) begin
            phase_d = '0;
            wrap_d  = 1'b1;
          end else begin
            phase_d = phase_q + ONE;
          end
        end
      endcase
      if (mode == MODE_SQR) r2r_out_d = (phase_d > (peak >> 1)) ? peak : '0;
      else                  r2r_out_d = phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      dir_q     <= DIR_UP;
      r2r_out_q <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      r2r_out_q <= r2r_out_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
    end
  end

  // Tracking the live mode through reset avoids a spurious mode change on release.
  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  assign r2r_out = r2r_out_q;
  assign step    = step_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Scoreboard bench for r2r_dac_wavegen (DAC_W=4, DIV_W=8); amp tests under R2R_WAVEGEN_AMP_EN.
module tb_r2r_dac_wavegen;

  localparam int DAC_W = 4;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic [DAC_W-1:0] data = '0;
  logic [DIV_W-1:0] div_data = '0;
  logic             load_divider = 1'b0;
`ifdef R2R_WAVEGEN_AMP_EN
  logic [DAC_W-1:0] amp = 4'hF;
`endif
  logic [DAC_W-1:0] r2r_out;
  logic             step;
  logic             wrap;

  r2r_dac_wavegen #(.DAC_W(DAC_W), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .data         (data),
    .div_data     (div_data),
    .load_divider (load_divider),
`ifdef R2R_WAVEGEN_AMP_EN
    .amp          (amp),
`endif
    .r2r_out      (r2r_out),
    .step         (step),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DAC_W-1:0] out;
    logic             stp;
    logic             wr;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] m, input int n);
    mode = m;
    rst  = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic load_div(input int v);
    div_data     = DIV_W'(v);
    load_divider = 1'b1;
    tick();
    load_divider = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    apply_reset(2'd1, 2);
    got = {r2r_out, step, wrap};
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_initial: got %h, expected 0", got);
    end
    load_div(2);
    repeat (10) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(obs_t'(0));
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h, expected %h", i, got, e);
      end
    end
    rst = 1'b0;
    // div is cleared by reset, so steps resume on every edge
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({DAC_W'(k), 1'b1, 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %h, expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_ext();
    obs_t got, e;
    logic [DAC_W-1:0] v;
    apply_reset(2'd0, 2);
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 4'hA : DAC_W'($urandom);
      data = v;
      exp_q.push_back({v, 1'b0, 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL ext[%0d]: got %h, expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_saw();
    obs_t got, e;
    int n;
    apply_reset(2'd1, 2);
    load_div(2);
    for (int k = 1; k <= 100; k++) begin
      n = (k / 3) % 16;
      exp_q.push_back({DAC_W'(n), (k % 3 == 0), (k % 3 == 0) && (n == 0)});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL saw[%0d]: got %h, expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_tri();
    obs_t got, e;
    int p;
    apply_reset(2'd2, 2);
    load_div(0);
    for (int k = 1; k <= 65; k++) begin
      p = k % 30;
      exp_q.push_back({DAC_W'((p <= 15) ? p : 30 - p), 1'b1, (p == 0)});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL tri[%0d]: got %h, expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_load_collision();
    obs_t got, e;
    apply_reset(2'd1, 2);
    load_div(2);
    exp_q.push_back({4'd0, 1'b0, 1'b0});
    exp_q.push_back({4'd0, 1'b0, 1'b0});
    exp_q.push_back({4'd1, 1'b1, 1'b0});
    exp_q.push_back({4'd1, 1'b0, 1'b0});
    exp_q.push_back({4'd1, 1'b0, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) begin
        div_data     = 8'd5;
        load_divider = 1'b1;
      end else begin
        load_divider = 1'b0;
      end
      if (k >= 6) exp_q.push_back({(k == 12) ? 4'd2 : 4'd1, (k == 12), 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL load_collision[%0d]: got %h, expected %h", k, got, e);
      end
    end
    load_divider = 1'b0;
  endtask

  task automatic test_sqr_mode_change();
    obs_t got, e;
    int p;
    apply_reset(2'd1, 2);
    load_div(0);
    repeat (4) tick();
    mode = 2'd3;
    exp_q.push_back(obs_t'(0));
    tick();
    e = exp_q.pop_front();
    got = {r2r_out, step, wrap};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL mode_change: got %h, expected %h", got, e);
    end
    for (int k = 1; k <= 40; k++) begin
      p = k % 16;
      exp_q.push_back({(p > 7) ? 4'hF : 4'h0, 1'b1, (p == 0)});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL sqr[%0d]: got %h, expected %h", k, got, e);
      end
    end
  endtask

`ifdef R2R_WAVEGEN_AMP_EN
  task automatic test_amp();
    obs_t got, e;
    int p;
    amp = 4'd5;
    for (int m = 1; m <= 3; m += 2) begin
      apply_reset(2'(m), 2);
      load_div(0);
      for (int k = 1; k <= 20; k++) begin
        p = k % 6;
        if (m == 1) exp_q.push_back({DAC_W'(p), 1'b1, (p == 0)});
        else        exp_q.push_back({(p >= 3) ? 4'd5 : 4'd0, 1'b1, (p == 0)});
        tick();
        e = exp_q.pop_front();
        got = {r2r_out, step, wrap};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL amp5_mode%0d[%0d]: got %h, expected %h", m, k, got, e);
        end
      end
    end
    amp = 4'd0;
    apply_reset(2'd1, 2);
    load_div(0);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back({4'd0, 1'b1, 1'b1});
      tick();
      e = exp_q.pop_front();
      got = {r2r_out, step, wrap};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL amp0[%0d]: got %h, expected %h", k, got, e);
      end
    end
    amp = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_ext();
    test_saw();
    test_tri();
    test_load_collision();
    test_sqr_mode_change();
`ifdef R2R_WAVEGEN_AMP_EN
    test_amp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
